// File: rtl/btn_debounce.sv
// Push-button synchroniser and four-state debouncer with press/release/long strobes
// and a 2-bit press-cycled speed selector. Optional long-press via `BTN_LONGPRESS_EN.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [1:0] speed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level_nx, press_nx, release_nx;
    logic [1:0]       speed_nx;

`ifdef BTN_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold, hold_nx;
    logic              fired, fired_nx;
    logic              long_nx;
`endif

    // Polarity is normalised before the first flop so s1/s2 always mean pressed = 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw ^ BTN_ACTIVE_LOW;
            s2 <= s1;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        level_nx   = btn_level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        speed_nx   = speed;
`ifdef BTN_LONGPRESS_EN
        hold_nx    = hold;
        fired_nx   = fired;
        long_nx    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DOWN;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    press_nx = 1'b1;
                    speed_nx = speed + 2'd1;
`ifdef BTN_LONGPRESS_EN
                    hold_nx  = '0;
                    fired_nx = 1'b0;
`endif
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                if (!s2) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = '0;
                end
`ifdef BTN_LONGPRESS_EN
                // hold freezes once the strobe has fired, so it never wraps.
                else if (!fired) begin
                    if (hold == HOLD_LAST) begin
                        long_nx  = 1'b1;
                        speed_nx = 2'd0;
                        fired_nx = 1'b1;
                    end else begin
                        hold_nx = hold + HOLD_W'(1);
                    end
                end
`endif
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed resumes the same press; hold is kept.
                if (s2) begin
                    state_nx = DOWN;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            speed         <= 2'd0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            btn_level     <= level_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            speed         <= speed_nx;
        end
    end

`ifdef BTN_LONGPRESS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            fired      <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            hold       <= hold_nx;
            fired      <= fired_nx;
            long_pulse <= long_nx;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised scoreboard bench for btn_debounce; reference model works on the
// run length of the synchronised input rather than on FSM states.
module tb_btn_debounce;

    localparam int DC = 4;
    localparam int LC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b1;
    logic       btn_level, press_pulse, release_pulse, long_pulse;
    logic [1:0] speed;

    always #5 clk = ~clk;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .LONG_CYCLES    (LC),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .speed        (speed)
    );

    typedef struct {
        int cyc;
        int kind;   // 1 press, 2 release, 3 long
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  ecnt = 0;
    bit  started = 1'b0;

    // Reference model state: sample pipeline, current run of equal s2 values,
    // accepted level, speed and edges counted while settled in the pressed state.
    int m_a = 0, m_b = 0, m_prev = 0, m_runv = 0, m_run = 0;
    int m_level = 0, m_speed = 0, m_hold = 0;

    task automatic model_edge(input logic r, input logic raw);
        int s2c;
        int down;
        if (r) begin
            m_a = 0; m_b = 0; m_prev = 0; m_runv = 0; m_run = 0;
            m_level = 0; m_speed = 0; m_hold = 0;
            return;
        end
        s2c = m_b;
        m_b = m_a;
        m_a = raw ? 0 : 1;
        if (s2c == m_runv) m_run++;
        else begin
            m_runv = s2c;
            m_run  = 1;
        end
        down = (m_level == 1 && m_prev == 1) ? 1 : 0;
        if (m_level == 0 && m_runv == 1 && m_run == DC + 1) begin
            m_level = 1;
            m_speed = (m_speed + 1) % 4;
            m_hold  = 0;
            q.push_back('{cyc: ecnt, kind: 1});
        end else if (m_level == 1 && m_runv == 0 && m_run == DC + 1) begin
            m_level = 0;
            q.push_back('{cyc: ecnt, kind: 2});
        end else if (down == 1 && s2c == 1) begin
`ifdef BTN_LONGPRESS_EN
            m_hold++;
            if (m_hold == LC) begin
                m_speed = 0;
                q.push_back('{cyc: ecnt, kind: 3});
            end
`endif
        end
        m_prev = s2c;
    endtask

    task automatic step(input logic r, input logic raw);
        @(negedge clk);
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        ecnt++;
        model_edge(r, raw);
        started = 1'b1;
    endtask

    task automatic hold_for(input logic raw, input int n);
        for (int i = 0; i < n; i++) step(1'b0, raw);
    endtask

    // Monitor: compares registered outputs each cycle and pops expected strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                int got;
                int expk;
                n_chk++;
                if (btn_level !== (m_level != 0)) begin
                    n_fail++;
                    $display("FAIL btn_level cyc=%0d got=%0b want=%0d", ecnt, btn_level, m_level);
                end
                n_chk++;
                if (speed !== 2'(m_speed)) begin
                    n_fail++;
                    $display("FAIL speed cyc=%0d got=%0d want=%0d", ecnt, speed, m_speed);
                end
                case ({press_pulse, release_pulse, long_pulse})
                    3'b000:  got = 0;
                    3'b100:  got = 1;
                    3'b010:  got = 2;
                    3'b001:  got = 3;
                    default: got = 9;
                endcase
                expk = 0;
                if (q.size() > 0 && q[0].cyc == ecnt) begin
                    expk = q[0].kind;
                    void'(q.pop_front());
                end
                if (got != 0 || expk != 0) begin
                    n_chk++;
                    if (got != expk) begin
                        n_fail++;
                        $display("FAIL strobe cyc=%0d got_kind=%0d want_kind=%0d", ecnt, got, expk);
                    end
                end
            end
        end
    end

    initial begin
        int len;
        logic v;
        // Reset, then released pin for 20 cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        hold_for(1'b1, 20);
        // Clean press held long enough for the long-press strobe, then release.
        hold_for(1'b0, 25);
        hold_for(1'b1, 12);
        // Bounces with 3-cycle lows, then a clean press.
        for (int i = 0; i < 4; i++) begin
            hold_for(1'b0, 3);
            hold_for(1'b1, 1);
        end
        hold_for(1'b0, 8);
        hold_for(1'b1, 10);
        // Five short presses walk speed through its wrap.
        for (int i = 0; i < 5; i++) begin
            hold_for(1'b0, 9);
            hold_for(1'b1, 10);
        end
        // Reset in the middle of debouncing a press while the button stays held.
        hold_for(1'b0, 5);
        step(1'b1, 1'b0);
        hold_for(1'b0, 12);
        hold_for(1'b1, 10);
        // Long hold; without the long-press feature speed must not move.
        hold_for(1'b0, 35);
        hold_for(1'b1, 10);
        // Random bounce patterns with occasional resets.
        for (int i = 0; i < 300; i++) begin
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 6));
            if ($urandom_range(0, 99) == 0) step(1'b1, v);
            hold_for(v, len);
        end
        hold_for(1'b1, 12);
        started = 1'b0;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events got=%0d want=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Upstream input stage for the LED sweep on the Trilby HAT. Synchronises the raw push-button pin and debounces it with a four-state FSM. Produces a clean level that drives the sweep's `btn` speed-boost input, plus single-cycle press/release/long-press strobes and a 2-bit speed selector that cycles on each press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000, cycles a new input value must stay stable before it is accepted (10 ms at 25 MHz); must be ≥ 1.
- `LONG_CYCLES`, 25000000, cycles in DOWN before `long_pulse` fires (1 s at 25 MHz); must be ≥ 1.
- `BTN_ACTIVE_LOW`, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `btn_raw`  in  1  asynchronous button pin.
- `btn_level`  out  1  debounced level, 1 = pressed.
- `press_pulse`  out  1  one-cycle strobe when a press is accepted.
- `release_pulse`  out  1  one-cycle strobe when a release is accepted.
- `long_pulse`  out  1  one-cycle strobe when a press has been held for `LONG_CYCLES`.
- `speed`  out  2  press counter, wraps 3→0.

## Operation
- Synchroniser: two flops, `s1` then `s2`, sampling `btn_raw` after polarity normalisation (pressed = 1).
- The FSM reads only `s2`.
- FSM states and transitions:
  - IDLE: `btn_level`=0. If `s2`=1, go to PRESS_WAIT with `cnt`←0.
  - PRESS_WAIT: if `s2`=0, return to IDLE and clear `cnt`, no strobe. Otherwise, when `cnt`==`DEBOUNCE_CYCLES`-1, go to DOWN: `btn_level`←1, `press_pulse`←1, `speed`←`speed`+1, `hold`←0. Otherwise `cnt`←`cnt`+1.
  - DOWN: if `s2`=0, go to RELEASE_WAIT with `cnt`←0. Otherwise `hold` counts (see Configuration).
  - RELEASE_WAIT: if `s2`=1, return to DOWN and clear `cnt`. The `hold` count and long-fired flag are kept, not restarted. When `cnt`==`DEBOUNCE_CYCLES`-1, go to IDLE: `btn_level`←0, `release_pulse`←1.
- Glitches shorter than `DEBOUNCE_CYCLES` never change `btn_level` and never produce a strobe.
- Arithmetic and widths:
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`; `hold` width is `$clog2(LONG_CYCLES+1)`.
  - Neither counter wraps: both are compared for equality and then cleared or frozen.
- `speed` is 2 bits with modulo-4 wrap: a press at 3 gives 0.
- At most one strobe is active in any cycle. Press, release and long-press cannot coincide by construction.
- Reset, synchronous, takes priority over everything:
  - `s1`/`s2` are cleared to the released value; state = IDLE; `cnt`=`hold`=0.
  - All outputs are 0, including `speed`.
  - Reset mid-press aborts the press with no strobe. A button still held after reset is accepted as a new press after full debounce.

## Timing
- Every output is a register; no combinational path from `btn_raw` to any output.
- Press latency: for a clean edge on `btn_raw` sampled at edge 1, `btn_level` and `press_pulse` rise after edge 3+`DEBOUNCE_CYCLES`.
- Release latency is the same as press latency.
- `press_pulse`, `release_pulse` and `long_pulse` are high for exactly one cycle.
- `long_pulse` rises `LONG_CYCLES` edges after the edge that entered DOWN. Cycles spent in RELEASE_WAIT during a bounce are not counted.
- Throughput: a new press can be accepted 3+`DEBOUNCE_CYCLES` cycles after a release is accepted.

## Configuration
- Macro: `BTN_LONGPRESS_EN`.
- Defined:
  - In DOWN, `hold` increments each cycle.
  - At `hold`==`LONG_CYCLES`-1, `long_pulse`←1 and `speed`←0. This fires once per press, tracked by a long-fired flag cleared on entry from PRESS_WAIT.
  - `hold` saturates after the strobe.
- Undefined:
  - The `hold` counter and flag are not built.
  - `long_pulse` is tied to 0; `speed` only changes on presses.
  - All other behaviour is identical.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `BTN_ACTIVE_LOW`=1, macro defined unless stated.
- Reset, then hold `btn_raw`=1 for 20 cycles → all outputs 0; `speed`=0.
- Drive `btn_raw` 1→0 and hold it → `btn_level` rises after edge 7; `press_pulse` high for exactly that cycle; `speed`=1.
- Bounce `btn_raw` with low widths of 3 cycles separated by 1 cycle high → `btn_level` stays 0 and no strobes fire. Then a clean 0 → press accepted 7 edges later.
- Keep the button pressed → `long_pulse` fires exactly once, 10 edges after DOWN entry, and `speed` becomes 0. Then release → `release_pulse` fires once, 7 edges after the `btn_raw` 0→1 edge.
- Give five clean presses, each shorter than `LONG_CYCLES` → `speed` goes 1, 2, 3, 0, 1.
- Assert `rst` in PRESS_WAIT at `cnt`=2 → no `press_pulse`. With the button still held after `rst` deasserts, the press is accepted at edge 7 after deassertion.
- Build with the macro undefined and hold the button for 30 cycles → `long_pulse` stays 0 and `speed` stays 1.
